rv32_ctrl3: RTL and testbench

RV32_CTRL3 -- requirements
Module: rv32_ctrl3

---
 rtl/rv32_ctrl3.sv | 221 ++++++++++++++++++++++
 tb/tb_rv32_ctrl3.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_ctrl3.sv
// rv32_ctrl3 -- control unit for a small RV32 subset core.
//
// Decodes the fetched instruction into a 13-bit datapath control vector
// and sequences a four-state FSM (RST, RUN, FLUSH, HALT). A taken branch or
// jump is followed by one FLUSH cycle that kills the wrongly fetched
// instruction. Unsupported encodings halt the core with a sticky illegal
// flag; ECALL/EBREAK halt it cleanly.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   inst     in   [31:0] instruction from the fetch path
//   br_eq    in   1 when the two register operands compare equal
//   ctrl     out  [0:12] control vector (bit 0 is the MSB):
//                 0 pc_sel, 1 reg_we, 2:4 imm type, 5 alu_src_imm,
//                 6:8 alu op, 9 mem_we, 10 wb_sel_mem, 11 retire, 12 mem_re
//   halted   out  1 while in HALT
//   illegal  out  sticky: HALT was reached through an unsupported encoding
//   instret  out  [CNT_W-1:0] retired-instruction counter, wraps silently
module rv32_ctrl3 #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      inst,
   input  logic             br_eq,
   output logic [0:12]      ctrl,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      ST_RST   = 2'b00,
      ST_RUN   = 2'b01,
      ST_FLUSH = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_SYS = 7'b1110011;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b100;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   state_t           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_b5;
   logic       inst_unused;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign funct7_b5   = inst[30];
   // Register indices and immediates belong to the datapath, not to decode.
   assign inst_unused = ^{inst[31], inst[29:15], inst[11:7]};

   // Returns {supported, alu_op}; sub selects SUB for funct3 000.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub);
      logic [3:0] r;
      case (f3)
         3'b000:  r = {1'b1, (sub ? ALU_SUB : ALU_ADD)};
         3'b111:  r = {1'b1, ALU_AND};
         3'b110:  r = {1'b1, ALU_OR};
         3'b100:  r = {1'b1, ALU_XOR};
         3'b010:  r = {1'b1, ALU_SLT};
         3'b001:  r = {1'b1, ALU_SLL};
         3'b101:  r = {1'b1, ALU_SRL};
         default: r = {1'b0, ALU_ADD};
      endcase
      return r;
   endfunction

   logic       pc_sel, reg_we, alu_src, mem_we, wb_mem, retire, mem_re;
   logic [2:0] imm_t, alu_op;
   logic [3:0] alu_dec;
   logic       bad, sys;

   always_comb begin
      pc_sel    = 1'b0;
      reg_we    = 1'b0;
      imm_t     = IMM_I;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      mem_we    = 1'b0;
      wb_mem    = 1'b0;
      retire    = 1'b0;
      mem_re    = 1'b0;
      alu_dec   = 4'b0000;
      bad       = 1'b0;
      sys       = 1'b0;
      state_d   = state_q;
      illegal_d = illegal_q;

      case (state_q)
         ST_RST: state_d = ST_RUN;

         ST_RUN: begin
            case (opcode)
               OP_R: begin
                  alu_dec = alu_decode(funct3, funct7_b5);
                  if (alu_dec[3]) begin
                     reg_we = 1'b1;
                     alu_op = alu_dec[2:0];
                     retire = 1'b1;
                  end else begin
                     bad = 1'b1;
                  end
               end
               OP_I: begin
                  // inst[30] is immediate data here, so there is no SUBI.
                  alu_dec = alu_decode(funct3, 1'b0);
                  if (alu_dec[3]) begin
                     reg_we  = 1'b1;
                     alu_src = 1'b1;
                     alu_op  = alu_dec[2:0];
                     retire  = 1'b1;
                  end else begin
                     bad = 1'b1;
                  end
               end
               OP_LD: begin
                  if (funct3 == 3'b010) begin
                     reg_we  = 1'b1;
                     alu_src = 1'b1;
                     wb_mem  = 1'b1;
                     mem_re  = 1'b1;
                     retire  = 1'b1;
                  end else begin
                     bad = 1'b1;
                  end
               end
               OP_ST: begin
                  if (funct3 == 3'b010) begin
                     mem_we  = 1'b1;
                     alu_src = 1'b1;
                     imm_t   = IMM_S;
                     retire  = 1'b1;
                  end else begin
                     bad = 1'b1;
                  end
               end
               OP_BR: begin
                  if (funct3 == 3'b000 || funct3 == 3'b001) begin
                     imm_t  = IMM_B;
                     alu_op = ALU_SUB;
                     retire = 1'b1;
                     // funct3[0] distinguishes BNE from BEQ.
                     pc_sel = br_eq ^ funct3[0];
                  end else begin
                     bad = 1'b1;
                  end
               end
               OP_JAL: begin
                  imm_t  = IMM_J;
                  pc_sel = 1'b1;
                  retire = 1'b1;
               end
               OP_SYS: begin
                  retire = 1'b1;
                  sys    = 1'b1;
               end
               default: bad = 1'b1;
            endcase

            if (bad) begin
               state_d   = ST_HALT;
               illegal_d = 1'b1;
            end else if (sys) begin
               state_d = ST_HALT;
            end else if (pc_sel) begin
               state_d = ST_FLUSH;
            end
         end

         // The instruction fetched behind a taken branch is discarded.
         ST_FLUSH: state_d = ST_RUN;

         default: state_d = ST_HALT;
      endcase

      ctrl      = {pc_sel, reg_we, imm_t, alu_src, alu_op, mem_we, wb_mem, retire, mem_re};
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   assign halted  = (state_q == ST_HALT);
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_rv32_ctrl3.sv
// Self-checking bench for rv32_ctrl3: a decode vector table, hand-written
// multi-cycle sequences (flush, halt, asynchronous reset, counter wrap) and
// a randomized run compared against an instruction-level reference model.
module tb_rv32_ctrl3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst = 32'h0;
   logic        br_eq = 1'b0;
   logic [0:12] ctrl;
   logic        halted, illegal;
   logic [31:0] instret;
   logic [0:12] ctrl4;
   logic        halted4, illegal4;
   logic [3:0]  instret4;

   int checks = 0;
   int errors = 0;

   rv32_ctrl3 #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .inst(inst), .br_eq(br_eq),
      .ctrl(ctrl), .halted(halted), .illegal(illegal), .instret(instret)
   );

   rv32_ctrl3 #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .inst(inst), .br_eq(br_eq),
      .ctrl(ctrl4), .halted(halted4), .illegal(illegal4), .instret(instret4)
   );

   always #5 clk = ~clk;

   // Layout: pc_sel | reg_we | imm[3] | src | alu[3] | mwe | wbm | ret | mre
   localparam logic [0:12] C_ZERO = 13'b0_0_000_0_000_0_0_0_0;
   localparam logic [0:12] C_ADD  = 13'b0_1_000_0_000_0_0_1_0;
   localparam logic [31:0] I_ADD  = 32'h002081B3;

   typedef struct {
      string       name;
      logic [31:0] inst;
      logic        br;
      logic [0:12] exp;
      int          nxt;   // 0 stay RUN, 1 FLUSH, 2 clean HALT, 3 illegal HALT
   } vec_t;

   vec_t vq[$];

   task automatic add_vec(input string n, input logic [31:0] i, input logic b,
                          input logic [0:12] e, input int nx);
      vec_t v;
      v.name = n; v.inst = i; v.br = b; v.exp = e; v.nxt = nx;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Leaves the DUT in RUN at a falling edge, ready for the next instruction.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      inst  = I_ADD;
      br_eq = 1'b0;
      #1;
      chk("rst ctrl", 32'(ctrl), 32'(C_ZERO));
      chk("rst halted", 32'(halted), 32'd0);
      chk("rst illegal", 32'(illegal), 32'd0);
      chk("rst instret", instret, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst-cycle ctrl", 32'(ctrl), 32'(C_ZERO));
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   typedef enum int {F_BAD, F_R, F_I, F_LW, F_SW, F_BEQ, F_BNE, F_JAL, F_SYS} fmt_t;

   // ALU operation code by funct3; -1 marks an unsupported funct3.
   int alu_by_f3[8] = '{0, 6, 5, -1, 4, 7, 3, 2};

   function automatic fmt_t classify(input logic [31:0] w);
      logic [6:0] op;
      logic [2:0] f3;
      op = w[6:0];
      f3 = w[14:12];
      if (op == 7'h33) return (alu_by_f3[f3] < 0) ? F_BAD : F_R;
      if (op == 7'h13) return (alu_by_f3[f3] < 0) ? F_BAD : F_I;
      if (op == 7'h03) return (f3 == 3'd2) ? F_LW : F_BAD;
      if (op == 7'h23) return (f3 == 3'd2) ? F_SW : F_BAD;
      if (op == 7'h63) return (f3 == 3'd0) ? F_BEQ : ((f3 == 3'd1) ? F_BNE : F_BAD);
      if (op == 7'h6F) return F_JAL;
      if (op == 7'h73) return F_SYS;
      return F_BAD;
   endfunction

   function automatic logic [0:12] model_ctrl(input logic [31:0] w, input logic b);
      logic [0:12] c;
      fmt_t        f;
      int          aop;
      c   = '0;
      f   = classify(w);
      aop = 0;
      if (f == F_R || f == F_I) aop = alu_by_f3[w[14:12]];
      if (f == F_R && w[14:12] == 3'd0 && w[30]) aop = 1;
      if (f != F_BAD) c[11] = 1'b1;
      case (f)
         F_R:   begin c[1] = 1'b1; c[6:8] = 3'(aop); end
         F_I:   begin c[1] = 1'b1; c[5] = 1'b1; c[6:8] = 3'(aop); end
         F_LW:  begin c[1] = 1'b1; c[5] = 1'b1; c[10] = 1'b1; c[12] = 1'b1; end
         F_SW:  begin c[9] = 1'b1; c[5] = 1'b1; c[2:4] = 3'b001; end
         F_BEQ: begin c[2:4] = 3'b010; c[6:8] = 3'b001; c[0] = b; end
         F_BNE: begin c[2:4] = 3'b010; c[6:8] = 3'b001; c[0] = !b; end
         F_JAL: begin c[2:4] = 3'b100; c[0] = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      logic [2:0]  f3;
      w  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 11))
         0, 1: w = {1'b0, w[30], 5'b0, w[24:15], f3, w[11:7], 7'h33};
         2, 3: w = {w[31:15], f3, w[11:7], 7'h13};
         4:    w = {w[31:15], ($urandom_range(0, 3) == 0) ? f3 : 3'd2, w[11:7], 7'h03};
         5:    w = {w[31:15], ($urandom_range(0, 3) == 0) ? f3 : 3'd2, w[11:7], 7'h23};
         6, 7: w = {w[31:15], ($urandom_range(0, 3) == 0) ? f3 : {2'b00, f3[0]}, w[11:7], 7'h63};
         8:    w = {w[31:7], 7'h6F};
         9:    w = {w[31:7], 7'h73};
         default: ;  // raw random word
      endcase
      return w;
   endfunction

   // ---------------- test ----------------
   initial begin
      add_vec("add",   32'h002081B3, 1'b0, 13'b0_1_000_0_000_0_0_1_0, 0);
      add_vec("sub",   32'h402081B3, 1'b0, 13'b0_1_000_0_001_0_0_1_0, 0);
      add_vec("and",   32'h0020F1B3, 1'b0, 13'b0_1_000_0_010_0_0_1_0, 0);
      add_vec("or",    32'h0020E1B3, 1'b0, 13'b0_1_000_0_011_0_0_1_0, 0);
      add_vec("xor",   32'h0020C1B3, 1'b0, 13'b0_1_000_0_100_0_0_1_0, 0);
      add_vec("slt",   32'h0020A1B3, 1'b0, 13'b0_1_000_0_101_0_0_1_0, 0);
      add_vec("sll",   32'h002091B3, 1'b0, 13'b0_1_000_0_110_0_0_1_0, 0);
      add_vec("srl",   32'h0020D1B3, 1'b0, 13'b0_1_000_0_111_0_0_1_0, 0);
      add_vec("addi",  32'h00500093, 1'b0, 13'b0_1_000_1_000_0_0_1_0, 0);
      add_vec("addi30",32'h40000093, 1'b0, 13'b0_1_000_1_000_0_0_1_0, 0);
      add_vec("xori",  32'h0040C093, 1'b0, 13'b0_1_000_1_100_0_0_1_0, 0);
      add_vec("sw",    32'h0020A023, 1'b0, 13'b0_0_001_1_000_1_0_1_0, 0);
      add_vec("lw",    32'h0000A183, 1'b0, 13'b0_1_000_1_000_0_1_1_1, 0);
      add_vec("beq-t", 32'h00208463, 1'b1, 13'b1_0_010_0_001_0_0_1_0, 1);
      add_vec("beq-n", 32'h00208463, 1'b0, 13'b0_0_010_0_001_0_0_1_0, 0);
      add_vec("bne-t", 32'h00209463, 1'b0, 13'b1_0_010_0_001_0_0_1_0, 1);
      add_vec("bne-n", 32'h00209463, 1'b1, 13'b0_0_010_0_001_0_0_1_0, 0);
      add_vec("jal",   32'h0080006F, 1'b0, 13'b1_0_100_0_000_0_0_1_0, 1);
      add_vec("ecall", 32'h00000073, 1'b0, 13'b0_0_000_0_000_0_0_1_0, 2);
      add_vec("ones",  32'hFFFFFFFF, 1'b0, C_ZERO, 3);
      add_vec("lb",    32'h00008183, 1'b0, C_ZERO, 3);
      add_vec("sltu",  32'h0020B1B3, 1'b0, C_ZERO, 3);
      add_vec("blt",   32'h0020C463, 1'b1, C_ZERO, 3);

      foreach (vq[k]) begin
         do_reset();
         inst  = vq[k].inst;
         br_eq = vq[k].br;
         #1;
         chk({vq[k].name, " ctrl"}, 32'(ctrl), 32'(vq[k].exp));
         @(negedge clk);
         inst  = I_ADD;
         br_eq = 1'b0;
         #1;
         chk({vq[k].name, " halted"}, 32'(halted), 32'(vq[k].nxt >= 2));
         chk({vq[k].name, " illegal"}, 32'(illegal), 32'(vq[k].nxt == 3));
         chk({vq[k].name, " instret"}, instret, 32'(vq[k].exp[11]));
         chk({vq[k].name, " next ctrl"}, 32'(ctrl), 32'((vq[k].nxt == 0) ? C_ADD : C_ZERO));
      end

      // Taken branch: flush ignores an illegal word, then RUN resumes.
      do_reset();
      inst = 32'h00208463; br_eq = 1'b1;
      #1 chk("br pc_sel", 32'(ctrl[0]), 32'd1);
      @(negedge clk);
      inst = 32'hFFFFFFFF; br_eq = 1'b0;
      #1 chk("flush ctrl", 32'(ctrl), 32'(C_ZERO));
      chk("flush instret", instret, 32'd1);
      @(negedge clk);
      inst = I_ADD;
      #1 chk("post-flush halted", 32'(halted), 32'd0);
      chk("post-flush illegal", 32'(illegal), 32'd0);
      chk("post-flush instret", instret, 32'd1);
      chk("post-flush ctrl", 32'(ctrl), 32'(C_ADD));

      // Illegal halt freezes the counter.
      do_reset();
      inst = 32'hFFFFFFFF;
      #1 chk("ill ctrl", 32'(ctrl), 32'(C_ZERO));
      @(negedge clk);
      inst = I_ADD;
      repeat (10) @(negedge clk);
      #1 chk("ill halted", 32'(halted), 32'd1);
      chk("ill sticky", 32'(illegal), 32'd1);
      chk("ill instret", instret, 32'd0);
      chk("ill ctrl frozen", 32'(ctrl), 32'(C_ZERO));

      // ECALL halt, then asynchronous reset mid-HALT.
      do_reset();
      inst = I_ADD;
      @(negedge clk);
      inst = 32'h00000073;
      #1 chk("ecall ctrl", 32'(ctrl), 32'(13'b0_0_000_0_000_0_0_1_0));
      @(negedge clk);
      inst = I_ADD;
      #1 chk("ecall halted", 32'(halted), 32'd1);
      chk("ecall illegal", 32'(illegal), 32'd0);
      chk("ecall instret", instret, 32'd2);
      #1 rst_n = 1'b0;
      #1 chk("async halted", 32'(halted), 32'd0);
      chk("async instret", instret, 32'd0);
      chk("async ctrl", 32'(ctrl), 32'(C_ZERO));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 chk("rerun ctrl", 32'(ctrl), 32'(C_ADD));

      // Asynchronous reset in the middle of a FLUSH cycle.
      do_reset();
      inst = 32'h0080006F;
      @(negedge clk);
      inst = I_ADD;
      #1 chk("jal flush instret", instret, 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("flush-rst instret", instret, 32'd0);
      chk("flush-rst ctrl", 32'(ctrl), 32'(C_ZERO));
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("flush-rst rst-cycle", 32'(ctrl), 32'(C_ZERO));
      @(negedge clk);
      #1 chk("flush-rst run", 32'(ctrl), 32'(C_ADD));

      // 4-bit counter wrap after 17 retirements.
      do_reset();
      inst = I_ADD;
      repeat (17) @(negedge clk);
      #1 chk("wrap instret4", 32'(instret4), 32'd1);
      chk("wrap instret32", instret, 32'd17);
      chk("wrap halted4", 32'(halted4), 32'd0);
      chk("wrap illegal4", 32'(illegal4), 32'd0);
      chk("wrap ctrl4", 32'(ctrl4), 32'(C_ADD));

      // Randomized run against the model.
      begin
         int          m_st;     // 0 RUN, 1 FLUSH, 2 HALT
         logic        m_bad;
         logic [31:0] m_cnt;
         int          hold;
         logic [0:12] e;
         fmt_t        f;
         do_reset();
         m_st = 0; m_bad = 1'b0; m_cnt = 32'd0; hold = 0;
         for (int n = 0; n < 2500; n++) begin
            if (m_st == 2 && hold >= 3) begin
               do_reset();
               m_st = 0; m_bad = 1'b0; m_cnt = 32'd0; hold = 0;
            end
            inst  = rand_inst();
            br_eq = 1'($urandom);
            #1;
            e = (m_st == 0) ? model_ctrl(inst, br_eq) : C_ZERO;
            chk("rnd ctrl", 32'(ctrl), 32'(e));
            chk("rnd halted", 32'(halted), 32'(m_st == 2));
            chk("rnd illegal", 32'(illegal), 32'(m_bad));
            chk("rnd instret", instret, m_cnt);
            if (m_st == 0) begin
               f = classify(inst);
               if (e[11]) m_cnt = m_cnt + 32'd1;
               if (f == F_BAD) begin m_st = 2; m_bad = 1'b1; end
               else if (f == F_SYS) m_st = 2;
               else if (e[0]) m_st = 1;
            end else if (m_st == 1) begin
               m_st = 0;
            end else begin
               hold++;
            end
            @(negedge clk);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
